// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed, XOR-protected image
// into instruction memory, then releases the MIPS core.
module imem_boot_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              done,
   output logic              err
);

   localparam logic [16:0]     DEPTH_L = 17'(2 ** ADDR_W);
   localparam logic [ADDR_W:0] ONE     = 1;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHK,
      S_RUN,
      S_ERR
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic            accept;
   logic [7:0]      len_hi;
   logic [15:0]     len_full;
   logic [ADDR_W:0] n_words;
   logic [ADDR_W:0] word_cnt;
   logic [1:0]      byte_cnt;
   logic [23:0]     asm_q;
   logic [7:0]      xor_q;
   logic            last_byte;
   logic            last_word;
   logic            overlong;

   // Ready depends on state alone so the sender never sees a loop
   assign rx_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CHK);

   assign accept    = rx_valid && rx_ready;
   assign len_full  = {len_hi, rx_data};
   assign overlong  = {1'b0, len_full} > DEPTH_L;
   assign last_byte = (byte_cnt == 2'd3);
   assign last_word = ((word_cnt + ONE) == n_words);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_LEN_HI;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: advance only on an accepted byte
   always_comb begin
      state_nx = state;
      unique case (state)
         S_LEN_HI: begin
            if (accept) begin
               state_nx = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               if (overlong) begin
                  state_nx = S_ERR;
               end else if (len_full == 16'd0) begin
                  state_nx = S_CHK;
               end else begin
                  state_nx = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept && last_byte && last_word) begin
               state_nx = S_CHK;
            end
         end
         S_CHK: begin
            if (accept) begin
               if (rx_data == xor_q) begin
                  state_nx = S_RUN;
               end else begin
                  state_nx = S_ERR;
               end
            end
         end
         S_RUN: state_nx = S_RUN;
         S_ERR: state_nx = S_ERR;
         default: state_nx = S_ERR;
      endcase
   end

   // Running checksum over every accepted byte
   always_ff @(posedge clk) begin
      if (reset) begin
         xor_q <= 8'h00;
      end else if (accept) begin
         xor_q <= xor_q ^ rx_data;
      end
   end

   // Length capture, word assembly and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         len_hi   <= 8'h00;
         n_words  <= '0;
         word_cnt <= '0;
         byte_cnt <= 2'd0;
         asm_q    <= 24'h0;
      end else if (accept) begin
         case (state)
            S_LEN_HI: len_hi <= rx_data;
            S_LEN_LO: begin
               n_words  <= len_full[ADDR_W:0];
               word_cnt <= '0;
               byte_cnt <= 2'd0;
            end
            S_DATA: begin
               byte_cnt <= byte_cnt + 2'd1;
               asm_q    <= {asm_q[15:0], rx_data};
               if (last_byte) begin
                  word_cnt <= word_cnt + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   // One-cycle imem write after the 4th byte; address/data hold otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'h0;
      end else begin
         imem_we <= 1'b0;
         if (accept && (state == S_DATA) && last_byte) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= {asm_q, rx_data};
         end
      end
   end

   // Registered status: core released only after a good checksum
   always_ff @(posedge clk) begin
      if (reset) begin
         core_reset <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (state_nx == S_RUN) begin
            core_reset <= 1'b0;
            done       <= 1'b1;
         end
         if (state_nx == S_ERR) begin
            err <= 1'b1;
         end
      end
   end

endmodule
